// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: loader state
// encoding, stream framing constants and small helpers used by the top and
// the byte packer.
package imem_loader_pkg;

    // Loader states; CSUM is only reachable when the checksum build option is on.
    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_e;

    // Header carries a little-endian 16-bit word count.
    localparam int HDR_BYTES  = 2;
    localparam int HDR_BITS   = HDR_BYTES * 8;

    // Instruction words are assembled from four stream bytes.
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input loader_state_e s);
        return (s inside {ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CSUM});
    endfunction

    // Byte address of a given word index (caller truncates to its port width).
    function automatic logic [31:0] word_to_byte_addr(input logic [HDR_BITS-1:0] idx);
        return 32'(idx) * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer: the first byte of each group lands in
// [7:0]. A word_valid pulse accompanies the byte that completes a word, with
// the fully assembled word on word_o in that same cycle.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       pack_q, pack_d;

    // Next lane / pack contents; completion is flagged on the last-lane byte.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lane_d       = lane_q;
        pack_d       = pack_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            lane_d = '0;
            pack_d = '0;
        end else if (byte_valid_i) begin
            pack_d[{lane_q, 3'b000} +: 8] = byte_i;
            lane_d       = lane_q + LANE_W'(1);
            word_valid_o = (lane_q == LAST_LANE);
        end
    end

    // The completed word includes the byte being accepted this cycle.
    assign word_o = pack_d;

    // Lane counter and pack register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Parses a 16-bit little-endian word
// count, packs the payload into 32-bit words, writes them from byte address 0
// and then releases the core via cpu_run. A zero count loads nothing and
// releases the core; a count above MAX_WORDS aborts with load_err.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// covering header and payload; a mismatch aborts with load_err.
// MAX_WORDS*4 must not exceed 2**ADDR_W.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_run,
    output logic                load_err,
    output logic [HDR_BITS-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_STATE = ST_CSUM;
`else
    localparam loader_state_e END_STATE = ST_DONE;
`endif

    loader_state_e       state_q, state_d;
    logic [HDR_BITS-1:0] count_q, count_d;
    logic [HDR_BITS-1:0] words_q, words_d;
    logic [HDR_BITS-1:0] words_inc;
    logic [HDR_BITS-1:0] hdr_count;
    logic                rx_ready_q, rx_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                done_q, done_d;
    logic                cpu_run_q, cpu_run_d;
    logic                load_err_q, load_err_d;

    logic                accept;
    logic                pack_valid;
    logic                pack_clear;
    logic                word_valid;
    logic [31:0]         word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    assign accept     = rx_valid && rx_ready_q;
    assign pack_valid = accept && (state_q == ST_DATA);
    // Keep the packer empty outside the payload so every load starts at lane 0.
    assign pack_clear = (state_q != ST_DATA);
    assign hdr_count  = {rx_data, count_q[7:0]};
    assign words_inc  = words_q + HDR_BITS'(1);

    imem_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state logic: header parse, payload completion, optional checksum.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = rx_data;
                    state_d      = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d = END_STATE;
                    end else if (hdr_count > HDR_BITS'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leave on the byte completing the last word so no stray byte is taken.
                if (word_valid && (words_inc == count_q)) begin
                    state_d = END_STATE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Output/datapath next values: memory write, word count, handshake, status.
    always_comb begin
        words_d      = words_q;
        imem_we_d    = word_valid;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (word_valid) begin
            words_d      = words_inc;
            imem_addr_d  = ADDR_W'(word_to_byte_addr(words_q));
            imem_wdata_d = word;
        end
        rx_ready_d = accepts_bytes(state_d);
        load_err_d = (state_d == ST_ERR);
        // Two-stage release keeps cpu_run low until the final write has landed.
        done_d     = (state_q == ST_DONE);
        cpu_run_d  = done_q;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted header and payload byte.
    always_comb begin
        csum_d = csum_q;
        if (accept && (state_q inside {ST_HDR_LO, ST_HDR_HI, ST_DATA})) begin
            csum_d = csum_q ^ rx_data;
        end
    end
`endif

    // All loader state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HDR_LO;
            count_q      <= '0;
            words_q      <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            done_q       <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            words_q      <= words_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            done_q       <= done_d;
            cpu_run_q    <= cpu_run_d;
            load_err_q   <= load_err_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accumulator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, normal load with latency, zero and
// oversize headers, gapped stream, mid-load reset, and (when
// IMEM_LOADER_CHECKSUM_EN is defined) checksum pass/fail.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              load_err;
    logic [15:0]       words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]        csum;
    logic [ADDR_W-1:0] wr_addr [$];
    logic [31:0]       wr_data [$];

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        csum = 8'h00;
        @(negedge clk);
    endtask

    // Present one byte from a falling edge; returns one falling edge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b expected 1", b, rx_ready);
        end
        @(negedge clk);
        csum     = csum ^ b;
        rx_valid = 1'b0;
    endtask

    // Checksum trailer byte in the checksum build; nothing otherwise.
    task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err, words_loaded} !== 60'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b/%b/%h/%h/%b/%b/%h, expected all zero",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err, words_loaded);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, expected 1", rx_ready);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0]  pl [0:11];
        logic [31:0] exp_d [0:2];
        pl    = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                  8'h33, 8'h01, 8'h11, 8'h00};
        exp_d = '{32'h0000_0013, 32'h0010_0093, 32'h0011_0133};
        apply_reset();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 12; i++) send_byte(pl[i]);
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h08 || imem_wdata !== 32'h0011_0133) begin
            miscompares++;
            $display("FAIL basic_last_write: got we=%b addr=%h data=%h, expected 1/08/00110133",
                     imem_we, imem_addr, imem_wdata);
        end
        vectors++;
        if (cpu_run !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run_during_write: got %b, expected 0", cpu_run);
        end
        send_trailer();
        @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b0 || imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run_early: got run=%b we=%b, expected 0/0", cpu_run, imem_we);
        end
        @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b1 || words_loaded !== 16'd3 || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run: got run=%b words=%0d err=%b, expected 1/3/0",
                     cpu_run, words_loaded, load_err);
        end
        vectors++;
        if (wr_addr.size() != 3) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d, expected 3", wr_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (((i < wr_addr.size()) ? wr_addr[i] : 8'hxx) !== 8'(i * 4) ||
                ((i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx) !== exp_d[i]) begin
                miscompares++;
                $display("FAIL basic_write_%0d: got %h/%h, expected %h/%h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 8'hxx,
                         (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx, 8'(i * 4), exp_d[i]);
            end
        end
    endtask

    task automatic test_zero_header();
        apply_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_trailer();
        repeat (3) @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b1 || load_err !== 1'b0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_hdr_state: got run=%b err=%b ready=%b, expected 1/0/0",
                     cpu_run, load_err, rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (rx_ready !== 1'b0 || words_loaded !== 16'd0 || wr_addr.size() != 0 || cpu_run !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_hdr_after: got ready=%b words=%0d writes=%0d run=%b, expected 0/0/0/1",
                     rx_ready, words_loaded, wr_addr.size(), cpu_run);
        end
    endtask

    task automatic test_oversize_header();
        apply_reset();
        send_byte(8'h41);
        send_byte(8'h00);
        vectors++;
        if (load_err !== 1'b1 || cpu_run !== 1'b0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_err: got err=%b run=%b ready=%b, expected 1/0/0",
                     load_err, cpu_run, rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (load_err !== 1'b1 || cpu_run !== 1'b0 || wr_addr.size() != 0 || words_loaded !== 16'd0) begin
            miscompares++;
            $display("FAIL oversize_sticky: got err=%b run=%b writes=%0d words=%0d, expected 1/0/0/0",
                     load_err, cpu_run, wr_addr.size(), words_loaded);
        end
        // Exactly MAX_WORDS is a legal length.
        apply_reset();
        send_byte(8'h40);
        send_byte(8'h00);
        vectors++;
        if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL max_len_accepted: got err=%b ready=%b, expected 0/1", load_err, rx_ready);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] pl [0:7];
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        apply_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(pl[i]);
            repeat ($urandom_range(0, 3)) begin
                rx_data = 8'($urandom);
                @(negedge clk);
            end
        end
        send_trailer();
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 2 || cpu_run !== 1'b1 || words_loaded !== 16'd2) begin
            miscompares++;
            $display("FAIL gaps_summary: got writes=%0d run=%b words=%0d, expected 2/1/2",
                     wr_addr.size(), cpu_run, words_loaded);
        end
        vectors++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h0000_0013 ||
            wr_addr[1] !== 8'h04 || wr_data[1] !== 32'h0010_0093) begin
            miscompares++;
            $display("FAIL gaps_words: got %0d writes, expected 00:00000013 04:00100093", wr_addr.size());
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err, words_loaded} !== 60'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b/%b/%h/%h/%b/%b/%h, expected all zero",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err, words_loaded);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'h4433_2211) begin
            miscompares++;
            $display("FAIL midreset_prior_writes: got %0d writes, expected 1 of 44332211", wr_addr.size());
        end
        wr_addr.delete();
        wr_data.delete();
        csum = 8'h00;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_trailer();
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDDCC_BBAA || cpu_run !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_fresh_load: got writes=%0d run=%b, expected one 00:DDCCBBAA and run=1",
                     wr_addr.size(), cpu_run);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        apply_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h09);
        repeat (3) @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL csum_good: got run=%b err=%b, expected 1/0", cpu_run, load_err);
        end
        apply_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        vectors++;
        if (cpu_run !== 1'b0 || load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL csum_bad: got run=%b err=%b, expected 0/1", cpu_run, load_err);
        end
    endtask
`endif

    initial begin
        csum = 8'h00;
        test_reset();
        test_basic_load();
        test_zero_header();
        test_oversize_header();
        test_gaps();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
